// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared defaults, controller states and requester id type.
package sram_ctrl_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_NUM_WMASKS = 4;
   typedef enum logic {INIT, RUN} state_t;
   typedef logic req_id_t;
endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: two-way round-robin grant; pointer flips to the other requester after any grant.
module sram_rr_arb2
   import sram_ctrl_pkg::*;
(
   input  logic       clk0,
   input  logic       rstb0,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant
);
   req_id_t ptr;
   always_comb grant = !en ? 2'b00 : (&valid) ? (ptr ? 2'b10 : 2'b01) : valid;
   always_ff @(posedge clk0)
      if (!rstb0) ptr <= 1'b0;
      else if (|grant) ptr <= grant[0];
endmodule

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: two-requester front end for one SRAM RW port with 1-cycle read responses.
// Define SRAM_ARB_INIT_EN to zero the whole SRAM after reset before accepting requests.
module sram_port0_arbiter
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
   input  logic                  clk0,
   input  logic                  rstb0,
   input  logic                  req_valid_0,
   output logic                  req_ready_0,
   input  logic                  req_we_0,
   input  logic [NUM_WMASKS-1:0] req_wmask_0,
   input  logic [ADDR_WIDTH-1:0] req_addr_0,
   input  logic [DATA_WIDTH-1:0] req_wdata_0,
   output logic                  rsp_valid_0,
   output logic [DATA_WIDTH-1:0] rsp_rdata_0,
   input  logic                  req_valid_1,
   output logic                  req_ready_1,
   input  logic                  req_we_1,
   input  logic [NUM_WMASKS-1:0] req_wmask_1,
   input  logic [ADDR_WIDTH-1:0] req_addr_1,
   input  logic [DATA_WIDTH-1:0] req_wdata_1,
   output logic                  rsp_valid_1,
   output logic [DATA_WIDTH-1:0] rsp_rdata_1,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  init_done
);
   logic [1:0] grant;
   logic run, xfer, we_g, pend, init_wr;
   logic [ADDR_WIDTH-1:0] init_addr;
   req_id_t gid, tag;
`ifdef SRAM_ARB_INIT_EN
   state_t state;
   logic [ADDR_WIDTH:0] init_cnt;
   // count 0 is an idle cycle; counts 1..2**ADDR_WIDTH write addresses 0..2**ADDR_WIDTH-1
   assign init_wr = rstb0 && state == INIT && init_cnt != '0;
   assign init_addr = init_cnt[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
   always_ff @(posedge clk0)
      if (!rstb0) begin
         state <= INIT;
         init_cnt <= '0;
         init_done <= 1'b0;
      end else if (state == INIT) begin
         init_cnt <= init_cnt + (ADDR_WIDTH+1)'(1);
         if (init_cnt[ADDR_WIDTH]) begin
            state <= RUN;
            init_done <= 1'b1;
         end
      end
`else
   assign init_wr = 1'b0;
   assign init_addr = '0;
   always_ff @(posedge clk0) init_done <= rstb0;
`endif
   assign run = rstb0 && init_done;
   sram_rr_arb2 u_arb (
      .clk0 (clk0),
      .rstb0(rstb0),
      .en   (run),
      .valid({req_valid_1, req_valid_0}),
      .grant(grant)
   );
   assign gid = grant[1];
   assign xfer = |grant;
   assign we_g = gid ? req_we_1 : req_we_0;
   assign req_ready_0 = grant[0];
   assign req_ready_1 = grant[1];
   always_comb begin
      sram_csb0 = !(xfer || init_wr);
      sram_web0 = init_wr ? 1'b0 : xfer ? !we_g : 1'b1;
      sram_wmask0 = init_wr ? '1 : xfer ? (gid ? req_wmask_1 : req_wmask_0) : '0;
      sram_addr0 = init_wr ? init_addr : gid ? req_addr_1 : req_addr_0;
      sram_din0 = init_wr ? '0 : gid ? req_wdata_1 : req_wdata_0;
   end
   always_ff @(posedge clk0)
      if (!rstb0) begin
         pend <= 1'b0;
         tag <= 1'b0;
      end else begin
         pend <= xfer && !we_g;
         tag <= gid;
      end
   // gating with rstb0 drops a response whose cycle coincides with reset
   assign rsp_valid_0 = rstb0 && pend && !tag;
   assign rsp_valid_1 = rstb0 && pend && tag;
   assign rsp_rdata_0 = rsp_valid_0 ? sram_dout0 : '0;
   assign rsp_rdata_1 = rsp_valid_1 ? sram_dout0 : '0;
endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb_sram_port0_arbiter: vector-table bench with a behavioural SRAM macro model.
module tb_sram_port0_arbiter;
   logic clk0 = 1'b0, rstb0, fill;
   logic req_valid_0, req_ready_0, req_we_0, rsp_valid_0;
   logic req_valid_1, req_ready_1, req_we_1, rsp_valid_1;
   logic [3:0] req_wmask_0, req_wmask_1, sram_wmask0;
   logic [8:0] req_addr_0, req_addr_1, sram_addr0;
   logic [31:0] req_wdata_0, req_wdata_1, rsp_rdata_0, rsp_rdata_1, sram_din0, sram_dout0;
   logic sram_csb0, sram_web0, init_done;
   logic [31:0] mem [512];
   int checks = 0, failures = 0;

   always #5 clk0 = ~clk0;

   sram_port0_arbiter dut (
      .clk0(clk0), .rstb0(rstb0),
      .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
      .req_wmask_0(req_wmask_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
      .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
      .req_wmask_1(req_wmask_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
      .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
      .init_done(init_done)
   );

   // SRAM macro: active-low chip select and write enable, byte masks, registered read data
   always @(posedge clk0)
      if (fill) begin
`ifdef SRAM_ARB_INIT_EN
         for (int i = 0; i < 512; i++) mem[i] <= 32'hA5A5A5A5;
`else
         for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
`endif
      end else if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
         end else sram_dout0 <= mem[sram_addr0];
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic v0, v1, we0, we1;
      logic [3:0] m0, m1;
      logic [8:0] a0, a1;
      logic [31:0] d0, d1;
      logic r0, r1, csb, web;
      logic [3:0] wm;
      logic [8:0] sa;
      logic rv0, rv1;
      logic [31:0] rd0, rd1;
   } vec_t;
   vec_t tbl [20];

   int n, k;
   logic bad_rdy, stray;

   initial begin
      // v0 v1 we0 we1 m0 m1 a0 a1 d0 d1 | r0 r1 csb web wm sa rv0 rv1 rd0 rd1
      tbl[0]  = '{1,0,1,0,4'h5,4'h0,9'h010,9'h000,32'hDEADBEEF,32'h0, 1,0,0,0,4'h5,9'h010, 0,0,32'h0,32'h0};
      tbl[1]  = '{1,0,0,0,4'h0,4'h0,9'h010,9'h000,32'h0,32'h0, 1,0,0,1,4'h0,9'h010, 0,0,32'h0,32'h0};
      tbl[2]  = '{0,0,0,0,4'h0,4'h0,9'h000,9'h000,32'h0,32'h0, 0,0,1,1,4'h0,9'h000, 1,0,32'h00AD00EF,32'h0};
      tbl[3]  = '{1,1,1,1,4'hF,4'hF,9'h001,9'h002,32'h11111111,32'h22222222, 0,1,0,0,4'hF,9'h002, 0,0,32'h0,32'h0};
      tbl[4]  = '{1,1,1,1,4'hF,4'hF,9'h001,9'h002,32'h11111111,32'h22222222, 1,0,0,0,4'hF,9'h001, 0,0,32'h0,32'h0};
      tbl[5]  = '{1,0,0,0,4'h0,4'h0,9'h001,9'h000,32'h0,32'h0, 1,0,0,1,4'h0,9'h001, 0,0,32'h0,32'h0};
      tbl[6]  = '{0,1,0,0,4'h0,4'h0,9'h000,9'h002,32'h0,32'h0, 0,1,0,1,4'h0,9'h002, 1,0,32'h11111111,32'h0};
      tbl[7]  = '{0,0,0,0,4'h0,4'h0,9'h000,9'h000,32'h0,32'h0, 0,0,1,1,4'h0,9'h000, 0,1,32'h0,32'h22222222};
      tbl[8]  = '{1,1,0,0,4'h0,4'h0,9'h001,9'h002,32'h0,32'h0, 1,0,0,1,4'h0,9'h001, 0,0,32'h0,32'h0};
      tbl[9]  = '{1,1,0,0,4'h0,4'h0,9'h001,9'h002,32'h0,32'h0, 0,1,0,1,4'h0,9'h002, 1,0,32'h11111111,32'h0};
      tbl[10] = '{1,1,0,0,4'h0,4'h0,9'h001,9'h002,32'h0,32'h0, 1,0,0,1,4'h0,9'h001, 0,1,32'h0,32'h22222222};
      tbl[11] = '{1,1,0,0,4'h0,4'h0,9'h001,9'h002,32'h0,32'h0, 0,1,0,1,4'h0,9'h002, 1,0,32'h11111111,32'h0};
      tbl[12] = '{1,1,0,0,4'h0,4'h0,9'h001,9'h002,32'h0,32'h0, 1,0,0,1,4'h0,9'h001, 0,1,32'h0,32'h22222222};
      tbl[13] = '{1,1,0,0,4'h0,4'h0,9'h001,9'h002,32'h0,32'h0, 0,1,0,1,4'h0,9'h002, 1,0,32'h11111111,32'h0};
      tbl[14] = '{0,0,0,0,4'h0,4'h0,9'h000,9'h000,32'h0,32'h0, 0,0,1,1,4'h0,9'h000, 0,1,32'h0,32'h22222222};
      tbl[15] = '{0,1,0,0,4'h0,4'h0,9'h000,9'h010,32'h0,32'h0, 0,1,0,1,4'h0,9'h010, 0,0,32'h0,32'h0};
      tbl[16] = '{0,1,0,0,4'h0,4'h0,9'h000,9'h010,32'h0,32'h0, 0,1,0,1,4'h0,9'h010, 0,1,32'h0,32'h00AD00EF};
      tbl[17] = '{0,1,0,0,4'h0,4'h0,9'h000,9'h010,32'h0,32'h0, 0,1,0,1,4'h0,9'h010, 0,1,32'h0,32'h00AD00EF};
      tbl[18] = '{1,1,0,0,4'h0,4'h0,9'h002,9'h001,32'h0,32'h0, 1,0,0,1,4'h0,9'h002, 0,1,32'h0,32'h00AD00EF};
      tbl[19] = '{0,0,0,0,4'h0,4'h0,9'h000,9'h000,32'h0,32'h0, 0,0,1,1,4'h0,9'h000, 1,0,32'h22222222,32'h0};

      rstb0 = 1'b0; fill = 1'b1;
      req_valid_0 = 1'b0; req_we_0 = 1'b0; req_wmask_0 = '0; req_addr_0 = '0; req_wdata_0 = '0;
      req_valid_1 = 1'b0; req_we_1 = 1'b0; req_wmask_1 = '0; req_addr_1 = '0; req_wdata_1 = '0;
      @(posedge clk0); #1 fill = 1'b0;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      @(posedge clk0);
      @(negedge clk0);
      chk("reset_ready0", {31'b0, req_ready_0}, 0);
      chk("reset_ready1", {31'b0, req_ready_1}, 0);
      chk("reset_csb", {31'b0, sram_csb0}, 1);
      chk("reset_init_done", {31'b0, init_done}, 0);
      chk("reset_rsp_valid", {30'b0, rsp_valid_1, rsp_valid_0}, 0);
      req_valid_1 = 1'b0;

`ifdef SRAM_ARB_INIT_EN
      // start a sweep, then pull reset while address 100 is being written
      req_valid_0 = 1'b0;
      @(posedge clk0); #1 rstb0 = 1'b1;
      k = 0;
      do begin
         @(negedge clk0);
         k++;
      end while (!(sram_csb0 == 1'b0 && sram_addr0 == 9'd100) && k < 1000);
      chk("init_reach_100", {23'b0, sram_addr0}, 100);
      rstb0 = 1'b0;
      #1 chk("init_abort_csb", {31'b0, sram_csb0}, 1);
      repeat (2) @(posedge clk0);
      req_valid_0 = 1'b1;
`endif

      // release and measure edges until init_done is seen
      @(posedge clk0); #1 rstb0 = 1'b1;
      @(negedge clk0);
      chk("first_cycle_init_done", {31'b0, init_done}, 0);
      chk("first_cycle_ready", {31'b0, req_ready_0}, 0);
      chk("first_cycle_csb", {31'b0, sram_csb0}, 1);
      n = 0; bad_rdy = 1'b0;
      do begin
         @(negedge clk0);
         n++;
`ifdef SRAM_ARB_INIT_EN
         if (n == 1) begin
            chk("init_restart_csb", {31'b0, sram_csb0}, 0);
            chk("init_restart_addr", {23'b0, sram_addr0}, 0);
            chk("init_wmask", {28'b0, sram_wmask0}, 32'hF);
         end
`endif
         if (!init_done && req_ready_0) bad_rdy = 1'b1;
      end while (!init_done && n < 2000);
      req_valid_0 = 1'b0;
`ifdef SRAM_ARB_INIT_EN
      chk("init_latency", n, 513);
`else
      chk("init_latency", n, 1);
`endif
      chk("ready_before_init_done", {31'b0, bad_rdy}, 0);
      @(posedge clk0); #1;

`ifdef SRAM_ARB_INIT_EN
      req_valid_0 = 1'b1; req_addr_0 = 9'h1FF;
      @(negedge clk0) chk("read_1ff_ready", {31'b0, req_ready_0}, 1);
      @(posedge clk0); #1 req_valid_0 = 1'b0;
      @(negedge clk0);
      chk("read_1ff_valid", {31'b0, rsp_valid_0}, 1);
      chk("read_1ff_data", rsp_rdata_0, 0);
      @(posedge clk0); #1;
`endif

      for (int i = 0; i < 20; i++) begin
         req_valid_0 = tbl[i].v0; req_we_0 = tbl[i].we0; req_wmask_0 = tbl[i].m0;
         req_addr_0 = tbl[i].a0; req_wdata_0 = tbl[i].d0;
         req_valid_1 = tbl[i].v1; req_we_1 = tbl[i].we1; req_wmask_1 = tbl[i].m1;
         req_addr_1 = tbl[i].a1; req_wdata_1 = tbl[i].d1;
         @(negedge clk0);
         chk($sformatf("v%0d_ready0", i), {31'b0, req_ready_0}, {31'b0, tbl[i].r0});
         chk($sformatf("v%0d_ready1", i), {31'b0, req_ready_1}, {31'b0, tbl[i].r1});
         chk($sformatf("v%0d_csb", i), {31'b0, sram_csb0}, {31'b0, tbl[i].csb});
         chk($sformatf("v%0d_web", i), {31'b0, sram_web0}, {31'b0, tbl[i].web});
         chk($sformatf("v%0d_wmask", i), {28'b0, sram_wmask0}, {28'b0, tbl[i].wm});
         if (!tbl[i].csb) chk($sformatf("v%0d_addr", i), {23'b0, sram_addr0}, {23'b0, tbl[i].sa});
         if (!tbl[i].web) chk($sformatf("v%0d_din", i), sram_din0, tbl[i].r1 ? tbl[i].d1 : tbl[i].d0);
         chk($sformatf("v%0d_rsp_valid0", i), {31'b0, rsp_valid_0}, {31'b0, tbl[i].rv0});
         chk($sformatf("v%0d_rsp_valid1", i), {31'b0, rsp_valid_1}, {31'b0, tbl[i].rv1});
         chk($sformatf("v%0d_rsp_rdata0", i), rsp_rdata_0, tbl[i].rd0);
         chk($sformatf("v%0d_rsp_rdata1", i), rsp_rdata_1, tbl[i].rd1);
         @(posedge clk0); #1;
      end

      // read in flight when reset arrives: its response must never appear
      req_valid_0 = 1'b1; req_valid_1 = 1'b0; req_we_0 = 1'b0; req_addr_0 = 9'h010;
      @(negedge clk0) chk("midread_ready0", {31'b0, req_ready_0}, 1);
      @(posedge clk0); #1;
      rstb0 = 1'b0; req_valid_1 = 1'b1;
      @(negedge clk0);
      chk("midread_rsp_dropped", {31'b0, rsp_valid_0}, 0);
      chk("midread_rdata_zero", rsp_rdata_0, 0);
      chk("reset_ready_both", {30'b0, req_ready_1, req_ready_0}, 0);
      chk("reset_csb_again", {31'b0, sram_csb0}, 1);
      @(posedge clk0); #1 rstb0 = 1'b1;
      k = 0; stray = 1'b0;
      do begin
         @(negedge clk0);
         k++;
         if (rsp_valid_0 || rsp_valid_1) stray = 1'b1;
      end while (!init_done && k < 1000);
      chk("rerun_init_done", {31'b0, init_done}, 1);
      chk("no_stray_rsp", {31'b0, stray}, 0);
      // pointer returns to requester 0 after reset
      chk("ptr_reset_ready0", {31'b0, req_ready_0}, 1);
      chk("ptr_reset_ready1", {31'b0, req_ready_1}, 0);
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      @(posedge clk0); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
